// File: rtl/calc_core.sv
// calc_core: iterative calculator responder (add/sub/mul/div/sqrt/gcd).
// Operands are latched on a start/ready handshake. The result comes back with a
// one-cycle done pulse, and err marks an invalid op or a divide by zero.
// Optional feature macro: CALC_GCD_EN. When it is defined, op=110 computes a
// subtractive gcd. When it is not defined, op=110 is treated as an invalid op.
module calc_core #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] opa,
    input  logic [DATA_WIDTH-1:0] opb,
    input  logic [2:0]            op,
    input  logic                  start,
    output logic                  ready,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  err
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);

    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_DIV  = 3'b100;
    localparam logic [2:0] OP_SQRT = 3'b101;
    localparam logic [2:0] OP_GCD  = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t          state, state_next;
    logic [2:0]      op_q;
    logic [W-1:0]    wa, wb, wa_n, wb_n;      // working operands
    logic [W+1:0]    acc, acc_n;              // product / partial remainder
    logic [CW-1:0]   cnt, steps;
    logic            last;
    logic [W+1:0]    shifted, trial;
    logic [W-1:0]    res_fin;
    logic            err_fin;
    logic [W-1:0]    result_q;
    logic            err_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Iteration budget per op; gcd instead stops when a working value reaches 0.
    // The budget always gives one extra EXEC cycle, so even add/sub see done at L=2.
    always_comb begin
        steps = '0;
        case (op_q)
            OP_MUL:  steps = CW'(W);
            OP_DIV:  steps = CW'(W);
            OP_SQRT: steps = CW'(W / 2);
            default: steps = '0;
        endcase
`ifdef CALC_GCD_EN
        if (op_q == OP_GCD) last = (wa == '0) || (wb == '0);
        else                last = (cnt == steps);
`else
        last = (cnt == steps);
`endif
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) state_next = S_EXEC;
            end
            S_EXEC: if (last) state_next = S_DONE;
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // One iteration step of the selected datapath
    always_comb begin
        wa_n    = wa;
        wb_n    = wb;
        acc_n   = acc;
        shifted = '0;
        trial   = '0;
        case (op_q)
            OP_MUL: begin
                // Shift-add: consume the multiplier LSB first, shift the multiplicand up.
                acc_n = acc + {2'b00, (wb[0] ? wa : '0)};
                wa_n  = {wa[W-2:0], 1'b0};
                wb_n  = {1'b0, wb[W-1:1]};
            end
            OP_DIV: begin
                // Restoring division: wa shifts the dividend out and the quotient in.
                shifted = {acc[W:0], wa[W-1]};
                trial   = shifted - {2'b00, wb};
                acc_n   = trial[W+1] ? shifted : trial;
                wa_n    = {wa[W-2:0], ~trial[W+1]};
            end
            OP_SQRT: begin
                // Bit-pair restoring root: wa holds the radicand, wb builds the root.
                shifted = {acc[W-1:0], wa[W-1:W-2]};
                trial   = shifted - {wb, 2'b01};
                acc_n   = trial[W+1] ? shifted : trial;
                wa_n    = {wa[W-3:0], 2'b00};
                wb_n    = {wb[W-2:0], ~trial[W+1]};
            end
`ifdef CALC_GCD_EN
            OP_GCD: begin
                // Subtractive Euclid: swap when a<b, otherwise subtract.
                if (wa < wb) begin
                    wa_n = wb;
                    wb_n = wa;
                end else begin
                    wa_n = wa - wb;
                end
            end
`endif
            default: ;
        endcase
    end

    // Final result selection, captured when EXEC finishes
    always_comb begin
        res_fin = '0;
        err_fin = 1'b0;
        case (op_q)
            OP_ADD:  res_fin = wa + wb;
            OP_SUB:  res_fin = wa - wb;
            OP_MUL:  res_fin = acc[W-1:0];
            OP_DIV: begin
                if (wb == '0) begin
                    res_fin = '1;
                    err_fin = 1'b1;
                end else begin
                    res_fin = wa;
                end
            end
            OP_SQRT: res_fin = wb;
`ifdef CALC_GCD_EN
            OP_GCD:  res_fin = wa | wb;
`endif
            default: err_fin = 1'b1;
        endcase
    end

    // Operand latch, iteration and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= '0;
            wa       <= '0;
            wb       <= '0;
            acc      <= '0;
            cnt      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else if (state == S_IDLE && start) begin
            op_q <= op;
            wa   <= opa;
            wb   <= (op == OP_SQRT) ? '0 : opb;
            acc  <= '0;
            cnt  <= '0;
        end else if (state == S_EXEC) begin
            if (last) begin
                result_q <= res_fin;
                err_q    <= err_fin;
            end else begin
                cnt <= cnt + 1'b1;
                wa  <= wa_n;
                wb  <= wb_n;
                acc <= acc_n;
            end
        end
    end

    assign result = result_q;
    assign err    = err_q;
endmodule
